// File: rtl/uart_cmd_link.sv
// UART command link: 8N1 receiver packing three bytes into a 24-bit command, plus a single-byte
// response transmitter. Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_cmd_link #(
    parameter int BAUD_DIV     = 347,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(TIMEOUT_BITS * BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * BAUD_DIV - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic            byte_ok, byte_bad;
`ifdef UART_PARITY_EN
    logic            rx_par_err, rx_par_err_n;
`endif

    logic [1:0]      byte_cnt;
    logic [TW-1:0]   idle_cnt;

    tx_state_t       tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_data, tx_data_n;
    logic            tx_line, tx_line_n;
    logic            resp_sent_n;

    // RX synchronizer presets high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
`ifdef UART_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            rx_meta    <= RX;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
`ifdef UART_PARITY_EN
            rx_par_err <= rx_par_err_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_err_n = rx_par_err;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches silently
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = '0;
`ifdef UART_PARITY_EN
                        rx_par_err_n = 1'b0;
`endif
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n     = '0;
                    rx_par_err_n = rx_sync ^ (^rx_shift);
                    rx_state_n   = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
                    if (rx_sync && !rx_par_err) byte_ok = 1'b1;
`else
                    if (rx_sync) byte_ok = 1'b1;
`endif
                    else byte_bad = 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Command assembly; a byte arriving while the previous command is unread is an overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= byte_bad | (byte_ok & cmd_rdy);
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (byte_ok && !cmd_rdy) begin
                case (byte_cnt)
                    2'd0:    cmd[23:16] <= rx_shift;
                    2'd1:    cmd[15:8]  <= rx_shift;
                    default: cmd[7:0]   <= rx_shift;
                endcase
                if (byte_cnt == 2'd2) begin
                    byte_cnt <= '0;
                    cmd_rdy  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (idle_cnt == TO_LAST) begin
                byte_cnt <= '0;
            end
            if (byte_cnt != 2'd0 && rx_state == RX_IDLE && idle_cnt != TO_LAST)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_data   <= '0;
            tx_line   <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_bit    <= tx_bit_n;
            tx_data   <= tx_data_n;
            tx_line   <= tx_line_n;
            resp_sent <= resp_sent_n;
        end
    end

    // The line level is registered alongside the state so TX never glitches
    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_bit_n    = tx_bit;
        tx_data_n   = tx_data;
        tx_line_n   = tx_line;
        resp_sent_n = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp && !resp_sent) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = '0;
                    tx_data_n  = resp_data;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_data[0];
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_n = TX_PARITY;
                        tx_line_n  = ^tx_data;
`else
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
`endif
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_line_n = tx_data[tx_bit + 3'd1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n  = TX_IDLE;
                    tx_cnt_n    = '0;
                    tx_line_n   = 1'b1;
                    resp_sent_n = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    assign TX      = tx_line;
    assign tx_busy = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: directed scenarios plus randomized traffic checked every cycle
// against a frame-level model. Honours UART_PARITY_EN for 11-bit frames.
module tb_uart_cmd_link;

    localparam int B       = 16;
    localparam int TO_BITS = 64;
    localparam int TO      = TO_BITS * B;
    localparam int HALF    = B / 2;
`ifdef UART_PARITY_EN
    localparam int NB          = 11;
    localparam int ACC_LIT     = 171;
    localparam int TX_LAT_LIT  = 177;
    localparam logic [10:0] PAT_A5 = 11'h54A;
`else
    localparam int NB          = 10;
    localparam int ACC_LIT     = 155;
    localparam int TX_LAT_LIT  = 161;
    localparam logic [10:0] PAT_A5 = 11'h34A;
`endif
    // Start-bit fall to stop-bit decision: 2 sync flops, edge detect, half bit, remaining bits
    localparam int ACC_DLY = 3 + HALF + (NB - 1) * B;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy, frm_err;
    logic [23:0] cmd;
    logic [7:0]  resp_data;

    uart_cmd_link #(.BAUD_DIV(B), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
        .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        int         st;
        logic [7:0] data;
        bit         good;
    } rx_ev_t;

    rx_ev_t      ev_q[$];
    rx_ev_t      ev;
    int          cyc = 0;
    int          n_cmp = 0, n_fail = 0;
    bit          chk_en = 0;
    bit          rx_done = 0;
    logic [23:0] exp_cmd;
    logic        exp_rdy, exp_err, old_rdy, prev_rdy = 1'b0;
    int          exp_cnt, last_end, tx_s;
    logic [10:0] tx_frame;
    int          cmp_rel, err_pulses = 0, rise_cyc = 0;

    function automatic logic [10:0] makeFrame(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: whole bytes land at their decision edge, responses are bit timelines
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            exp_cmd  = '0;
            exp_rdy  = 1'b0;
            exp_err  = 1'b0;
            exp_cnt  = 0;
            last_end = cyc;
            tx_s     = -100000;
            tx_frame = 11'h7FF;
        end else begin
            old_rdy = exp_rdy;
            exp_err = 1'b0;
            if (send_resp && cyc > tx_s + NB * B + 1) begin
                tx_s     = cyc;
                tx_frame = makeFrame(resp_data);
            end
            if (clr_cmd_rdy && old_rdy) exp_rdy = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].edge_no == cyc) begin
                ev = ev_q.pop_front();
                if (exp_cnt != 0 && ev.st - last_end >= TO) exp_cnt = 0;
                last_end = cyc;
                if (!ev.good || old_rdy) begin
                    exp_err = 1'b1;
                end else begin
                    exp_cmd[23 - 8 * exp_cnt -: 8] = ev.data;
                    if (exp_cnt == 2) begin
                        exp_cnt = 0;
                        exp_rdy = 1'b1;
                    end else begin
                        exp_cnt++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_rel = cyc - tx_s;
            checkOutput("cmd", 32'(cmd), 32'(exp_cmd));
            checkOutput("cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy));
            checkOutput("frm_err", 32'(frm_err), 32'(exp_err));
            checkOutput("tx_busy", 32'(tx_busy), 32'(cmp_rel >= 0 && cmp_rel < NB * B));
            checkOutput("resp_sent", 32'(resp_sent), 32'(cmp_rel == NB * B));
            checkOutput("TX", 32'(TX), 32'((cmp_rel >= 0 && cmp_rel < NB * B) ? tx_frame[cmp_rel / B] : 1'b1));
            if (frm_err) err_pulses++;
            if (cmd_rdy && !prev_rdy) rise_cyc = cyc;
            prev_rdy = cmd_rdy;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input bit stop_b, input bit pflip, output int start);
        logic [10:0] bits;
        rx_ev_t e;
`ifdef UART_PARITY_EN
        bits = {stop_b, (^d) ^ pflip, d, 1'b0};
`else
        bits = {1'b1, stop_b, d, 1'b0};
`endif
        @(posedge clk);
        #1;
        start     = cyc;
        e.edge_no = start + ACC_DLY;
        e.st      = start + 3;
        e.data    = d;
        e.good    = stop_b && !pflip;
        ev_q.push_back(e);
        for (int i = 0; i < NB; i++) begin
            RX = bits[i];
            repeat (B) @(posedge clk);
            #1;
        end
        RX = 1'b1;
    endtask

    task automatic idleCycles(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic pulseClr();
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
    endtask

    task automatic txProbe(input logic [7:0] d, input int second_at, input logic [10:0] exp_pat,
                           input int exp_lat);
        int n, lat, rel;
        logic [10:0] pat;
        @(posedge clk);
        #1;
        resp_data = d;
        send_resp = 1'b1;
        n = cyc;
        @(posedge clk);
        #1 send_resp = 1'b0;
        pat = '0;
        lat = -1;
        while (lat < 0 && cyc < n + 400) begin
            @(negedge clk);
            rel = cyc - n - 1;
            if (rel >= 0 && rel % B == HALF && rel / B < NB) pat[rel / B] = TX;
            if (resp_sent) lat = cyc - n;
            if (second_at > 0 && cyc - n == second_at - 1) begin
                resp_data = 8'h3C;
                send_resp = 1'b1;
            end else begin
                send_resp = 1'b0;
            end
        end
        send_resp = 1'b0;
        checkOutput("tx_pattern", 32'(pat), 32'(exp_pat));
        checkOutput("resp_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int n, n3, e0;
        logic [7:0] d;
        bit stop_b, pf;
        RX = 1'b1;
        rst = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        resp_data = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset_TX", 32'(TX), 32'd1);
        checkOutput("reset_cmd", 32'(cmd), 32'd0);
        checkOutput("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
        checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_resp_sent", 32'(resp_sent), 32'd0);
        checkOutput("reset_frm_err", 32'(frm_err), 32'd0);

        applyStimulus(8'h05, 1'b1, 1'b0, n);
        applyStimulus(8'hA3, 1'b1, 1'b0, n);
        applyStimulus(8'h7F, 1'b1, 1'b0, n3);
        @(negedge clk);
        checkOutput("cmd_first", 32'(cmd), 32'h05A37F);
        checkOutput("rdy_rise_latency", 32'(rise_cyc - n3), 32'(ACC_LIT));
        checkOutput("no_err_yet", 32'(err_pulses), 32'd0);

        applyStimulus(8'h11, 1'b1, 1'b0, n);
        idleCycles(4);
        @(negedge clk);
        checkOutput("overrun_err", 32'(err_pulses), 32'd1);
        checkOutput("overrun_cmd_kept", 32'(cmd), 32'h05A37F);
        pulseClr();
        @(negedge clk);
        checkOutput("clr_rdy", 32'(cmd_rdy), 32'd0);
        applyStimulus(8'h01, 1'b1, 1'b0, n);
        applyStimulus(8'h02, 1'b1, 1'b0, n);
        applyStimulus(8'h03, 1'b1, 1'b0, n);
        @(negedge clk);
        checkOutput("cmd_second", 32'(cmd), 32'h010203);

        pulseClr();
        applyStimulus(8'h22, 1'b1, 1'b0, n);
        idleCycles(TO + 1);
        applyStimulus(8'h33, 1'b1, 1'b0, n);
        applyStimulus(8'h44, 1'b1, 1'b0, n);
        applyStimulus(8'h55, 1'b1, 1'b0, n);
        @(negedge clk);
        checkOutput("cmd_timeout", 32'(cmd), 32'h334455);

        pulseClr();
        e0 = err_pulses;
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (4) @(posedge clk);
        #1 RX = 1'b1;
        idleCycles(40);
        @(negedge clk);
        checkOutput("glitch_no_err", 32'(err_pulses), 32'(e0));
        checkOutput("glitch_no_rdy", 32'(cmd_rdy), 32'd0);
        applyStimulus(8'h66, 1'b1, 1'b0, n);
        applyStimulus(8'h77, 1'b0, 1'b0, n);
        idleCycles(20);
        @(negedge clk);
        checkOutput("stop_err", 32'(err_pulses), 32'(e0 + 1));
        applyStimulus(8'h88, 1'b1, 1'b0, n);
        applyStimulus(8'h99, 1'b1, 1'b0, n);
        @(negedge clk);
        checkOutput("cmd_after_bad_stop", 32'(cmd), 32'h668899);

        pulseClr();
        txProbe(8'hA5, 50, PAT_A5, TX_LAT_LIT);

`ifdef UART_PARITY_EN
        e0 = err_pulses;
        applyStimulus(8'h07, 1'b1, 1'b1, n);
        idleCycles(20);
        @(negedge clk);
        checkOutput("parity_err", 32'(err_pulses), 32'(e0 + 1));
        applyStimulus(8'h0A, 1'b1, 1'b0, n);
        applyStimulus(8'h0B, 1'b1, 1'b0, n);
        applyStimulus(8'h0C, 1'b1, 1'b0, n);
        @(negedge clk);
        checkOutput("cmd_after_parity", 32'(cmd), 32'h0A0B0C);
        pulseClr();
        txProbe(8'h03, 0, 11'h406, 177);
`endif

        $display("[TB] directed phase done, starting random traffic");
        rx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    d = 8'($urandom);
                    stop_b = ($urandom_range(0, 7) != 0);
`ifdef UART_PARITY_EN
                    pf = ($urandom_range(0, 7) == 0);
`else
                    pf = 1'b0;
`endif
                    applyStimulus(d, stop_b, pf, n);
                    if ($urandom_range(0, 9) == 0)
                        idleCycles($urandom_range(1100, 1200));
                    else
                        idleCycles((!stop_b || pf) ? $urandom_range(20, 80) : $urandom_range(0, 80));
                end
                rx_done = 1'b1;
            end
            begin
                while (!rx_done) begin
                    idleCycles($urandom_range(20, 300));
                    @(posedge clk);
                    #1;
                    if ($urandom_range(0, 1) == 1) begin
                        resp_data = 8'($urandom);
                        send_resp = 1'b1;
                    end else begin
                        clr_cmd_rdy = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                    send_resp = 1'b0;
                    clr_cmd_rdy = 1'b0;
                end
            end
        join
        idleCycles(NB * B + 20);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
